// File: rtl/comp_mult_pkg.sv
// Shared state encoding and default parameters for the result/expected memory checker.
package comp_mult_pkg;

  localparam int DEF_DWIDTH    = 8;
  localparam int DEF_SYS_AW    = 16;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_RD_LAT    = 1;
  localparam int DEF_LOG_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    WAIT_A,
    RD_B,
    WAIT_B,
    CMP,
    FIN
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, zero-latency head view; a push into a full FIFO lands only if a pop happens
// in the same cycle, a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/res_mem_checker.sv
// Compares nr_words of a result region against an expected region, one word per 2*(1+RD_LAT)+1 cycles;
// mismatch indices go to a log FIFO drained via log_val/log_rdy, entries dropped (log_ovf) when full.
module res_mem_checker
  import comp_mult_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int SYS_AW    = DEF_SYS_AW,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst,
  input  logic              start,
  input  logic [SYS_AW-1:0] res_ba,
  input  logic [SYS_AW-1:0] exp_ba,
  input  logic [CNT_W-1:0]  nr_words,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              log_ovf,
  output logic              log_val,
  input  logic              log_rdy,
  output logic [CNT_W-1:0]  log_idx,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [SYS_AW-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rd_data
);

  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state;
  state_t            nxt;
  logic [SYS_AW-1:0] res_q;
  logic [SYS_AW-1:0] exp_q;
  logic [CNT_W-1:0]  nr_q;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_inc;
  logic [CNT_W-1:0]  err_q;
  logic [WW-1:0]     wcnt;
  logic [DWIDTH-1:0] a_q;
  logic [DWIDTH-1:0] b_q;
  logic              pass_q;
  logic              ovf_q;
  logic              accept;
  logic              wait_last;
  logic              mismatch;
  logic              push;
  logic              fifo_clr;
  logic              fifo_empty;
  logic              fifo_full;

  assign accept    = (state == IDLE) && start;
  assign wait_last = (wcnt == WW'(RD_LAT - 1));
  assign idx_inc   = idx + CNT_W'(1);
  assign mismatch  = (a_q != b_q);
  assign push      = (state == CMP) && mismatch;
  assign fifo_clr  = sw_rst || accept;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (nr_words == '0) ? FIN : RD_A;
      RD_A:    nxt = WAIT_A;
      WAIT_A:  if (wait_last) nxt = RD_B;
      RD_B:    nxt = WAIT_B;
      WAIT_B:  if (wait_last) nxt = CMP;
      CMP:     nxt = (idx_inc == nr_q) ? FIN : RD_A;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    if (state == RD_A) mem_addr = res_q + SYS_AW'(idx);
    if (state == RD_B) mem_addr = exp_q + SYS_AW'(idx);
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign pass    = done ? (err_q == '0) : pass_q;
  assign err_cnt = err_q;
  assign log_ovf = ovf_q;
  assign log_val = !fifo_empty;
  assign mem_ce  = (state == RD_A) || (state == RD_B);
  assign mem_we  = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      wcnt   <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (sw_rst) begin
      state  <= IDLE;
      idx    <= '0;
      wcnt   <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          idx    <= '0;
          wcnt   <= '0;
          err_q  <= '0;
          pass_q <= 1'b0;
          ovf_q  <= 1'b0;
        end
        WAIT_A, WAIT_B: wcnt <= wait_last ? '0 : wcnt + WW'(1);
        CMP: begin
          idx <= idx_inc;
          if (mismatch) begin
            if (err_q != '1) err_q <= err_q + CNT_W'(1);
            // full with no pop this cycle means the entry cannot be stored
            if (fifo_full && !log_rdy) ovf_q <= 1'b1;
          end
        end
        FIN: pass_q <= (err_q == '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      res_q <= res_ba;
      exp_q <= exp_ba;
      nr_q  <= nr_words;
    end
    if ((state == WAIT_A) && wait_last) a_q <= mem_rd_data;
    if ((state == WAIT_B) && wait_last) b_q <= mem_rd_data;
  end

  sync_fifo #(
    .DEPTH (LOG_DEPTH),
    .DW    (CNT_W)
  ) u_log (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (push),
    .push_data (idx),
    .pop       (log_rdy),
    .head      (log_idx),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
